// File: rtl/fft_pkg.sv
// Shared widths and FSM encoding for the FFT frame scheduler.
// Sample and result widths match the FFT core's fixed-point ports.
package fft_pkg;
  localparam int IN_W  = 14;
  localparam int OUT_W = 19;
  localparam int N     = 32;
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer remembers the last served channel.
// Reset leaves the pointer on ch1 so ch0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (adv) begin
      last_q <= gnt[1];
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/fft_frame_sched.sv
// Schedules whole frames from two sample streams into one FFT core
// and tags the FFT results with their owning channel and index.
module fft_frame_sched #(
  parameter int N       = fft_pkg::N,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0,
  input  logic                       req1,
  input  logic                       s0_valid,
  input  logic                       s1_valid,
  input  logic [fft_pkg::IN_W-1:0]   s0_data,
  input  logic [fft_pkg::IN_W-1:0]   s1_data,
  output logic                       gnt0,
  output logic                       gnt1,
  output logic                       fft_valid_o,
  output logic [fft_pkg::IN_W-1:0]   fft_x_o,
  input  logic                       fft_busy_i,
  input  logic                       fft_finish_i,
  input  logic [fft_pkg::OUT_W-1:0]  fft_Xr_i,
  input  logic [fft_pkg::OUT_W-1:0]  fft_Xi_i,
  output logic                       out_valid,
  output logic                       out_ch,
  output logic [fft_pkg::IDX_W-1:0]  out_idx,
  output logic                       out_last,
  output logic [fft_pkg::OUT_W-1:0]  out_Xr,
  output logic [fft_pkg::OUT_W-1:0]  out_Xi,
  output logic                       err_o
);
  import fft_pkg::*;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic               ch_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [WD_W-1:0]    wd_q;
  logic               fft_valid_q;
  logic [IN_W-1:0]    fft_x_q;
  logic               out_valid_q, out_ch_q, out_last_q;
  logic [IDX_W-1:0]   out_idx_q;
  logic [OUT_W-1:0]   out_xr_q, out_xi_q;
  logic               err_q;

  logic [1:0]         arb_gnt;
  logic               adv;
  logic               sel_valid;
  logic [IN_W-1:0]    sel_data;
  logic               feed_done, drain_last, wd_exp;
  logic               in_feed, in_drain;

  assign in_feed    = (state_q == FEED);
  assign in_drain   = (state_q == DRAIN);
  assign sel_valid  = ch_q ? s1_valid : s0_valid;
  assign sel_data   = ch_q ? s1_data : s0_data;
  assign adv        = (state_q == IDLE) && (req0 || req1) && !fft_busy_i;
  assign feed_done  = in_feed && sel_valid && (cnt_q == IDX_W'(N - 1));
  assign drain_last = in_drain && fft_finish_i && (cnt_q == IDX_W'(N - 1));
  assign wd_exp     = in_drain && !fft_finish_i && (wd_q == WD_W'(TIMEOUT - 1));

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1, req0}),
    .adv (adv),
    .gnt (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (adv) state_d = FEED;
      FEED:    if (feed_done) state_d = DRAIN;
      DRAIN:   if (drain_last || wd_exp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0 = in_feed && !ch_q;
    gnt1 = in_feed && ch_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q        <= 1'b0;
      cnt_q       <= '0;
      wd_q        <= '0;
      fft_valid_q <= 1'b0;
      fft_x_q     <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_xr_q    <= '0;
      out_xi_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (adv) ch_q <= arb_gnt[1] & ~arb_gnt[0];
      fft_valid_q <= in_feed && sel_valid;
      fft_x_q     <= in_feed ? sel_data : '0;
      // One counter: samples while feeding, results while draining.
      if (in_feed && sel_valid) begin
        cnt_q <= feed_done ? '0 : cnt_q + 1'b1;
      end else if (in_drain && fft_finish_i) begin
        cnt_q <= drain_last ? '0 : cnt_q + 1'b1;
      end else if (!in_feed && !in_drain) begin
        cnt_q <= '0;
      end
      wd_q        <= (in_drain && !fft_finish_i) ? wd_q + 1'b1 : '0;
      out_valid_q <= in_drain && fft_finish_i;
      out_last_q  <= drain_last;
      if (in_drain && fft_finish_i) begin
        out_ch_q  <= ch_q;
        out_idx_q <= cnt_q;
        out_xr_q  <= fft_Xr_i;
        out_xi_q  <= fft_Xi_i;
      end
      err_q <= err_q | wd_exp | (fft_finish_i && !in_drain);
    end
  end

  assign fft_valid_o = fft_valid_q;
  assign fft_x_o     = fft_x_q;
  assign out_valid   = out_valid_q;
  assign out_ch      = out_ch_q;
  assign out_idx     = out_idx_q;
  assign out_last    = out_last_q;
  assign out_Xr      = out_xr_q;
  assign out_Xi      = out_xi_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_fft_frame_sched.sv
// Scoreboard bench for fft_frame_sched: stimulus pushes expected
// forwarded samples and results, negedge monitor pops and compares.
module tb_fft_frame_sched;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic [13:0] s0_data = '0, s1_data = '0;
  logic        gnt0, gnt1, fft_valid_o;
  logic [13:0] fft_x_o;
  logic        fft_busy_i = 1'b0, fft_finish_i = 1'b0;
  logic [18:0] fft_Xr_i = '0, fft_Xi_i = '0;
  logic        out_valid, out_ch, out_last, err_o;
  logic [4:0]  out_idx;
  logic [18:0] out_Xr, out_Xi;

  typedef struct packed {
    logic        ch;
    logic [4:0]  idx;
    logic        last;
    logic [18:0] xr;
    logic [18:0] xi;
  } res_t;

  res_t        exp_res[$];
  logic [13:0] exp_x[$];
  res_t        mon_r;
  int          n_chk = 0;
  int          n_fail = 0;

  fft_frame_sched #(.N(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .s0_valid(s0_valid), .s1_valid(s1_valid),
    .s0_data(s0_data), .s1_data(s1_data),
    .gnt0(gnt0), .gnt1(gnt1),
    .fft_valid_o(fft_valid_o), .fft_x_o(fft_x_o),
    .fft_busy_i(fft_busy_i), .fft_finish_i(fft_finish_i),
    .fft_Xr_i(fft_Xr_i), .fft_Xi_i(fft_Xi_i),
    .out_valid(out_valid), .out_ch(out_ch), .out_idx(out_idx),
    .out_last(out_last), .out_Xr(out_Xr), .out_Xi(out_Xi),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) check("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
    if (fft_valid_o) begin
      if (exp_x.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected fft_valid_o: got x=%0h expected none", fft_x_o);
      end else begin
        check("fft_x", 64'(fft_x_o), 64'(exp_x.pop_front()));
      end
    end
    if (out_valid) begin
      if (exp_res.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected out_valid: got idx=%0d expected none", out_idx);
      end else begin
        mon_r = exp_res.pop_front();
        check("out_result", 64'({out_ch, out_idx, out_last, out_Xr, out_Xi}),
              64'(mon_r));
      end
    end
  end

  task automatic drv(input logic ch, input logic v, input logic [13:0] d);
    if (ch) begin s1_valid = v; s1_data = d; end
    else    begin s0_valid = v; s0_data = d; end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_flags", 64'({gnt0, gnt1, fft_valid_o, out_valid,
                            out_ch, out_last, err_o}), 64'd0);
    check("rst_fft_x", 64'(fft_x_o), 64'd0);
    check("rst_idx", 64'(out_idx), 64'd0);
    check("rst_xr_xi", 64'({out_Xr, out_Xi}), 64'd0);
  endtask

  task automatic wait_gnt(input logic ch);
    int k = 0;
    while (!(gnt0 | gnt1) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("gnt_seen", 64'(gnt0 | gnt1), 64'd1);
    check("gnt_owner", 64'({gnt1, gnt0}), ch ? 64'd2 : 64'd1);
  endtask

  // Other stream is noisy throughout; it must never reach the FFT.
  task automatic feed(input logic ch, input bit gap,
                      input logic [13:0] base, input int ncyc);
    int hc = 0;
    for (int i = 0; i < 32; i++) begin
      if (gap) begin
        drv(ch, 1'b0, '0);
        drv(!ch, 1'b1, 14'h1555);
        @(negedge clk); hc += int'(gnt0 | gnt1);
        @(posedge clk); #1;
      end
      drv(ch, 1'b1, base + 14'(i));
      drv(!ch, 1'b1, 14'h1555);
      exp_x.push_back(base + 14'(i));
      @(negedge clk); hc += int'(gnt0 | gnt1);
      @(posedge clk); #1;
    end
    drv(ch, 1'b0, '0);
    drv(!ch, 1'b0, '0);
    @(negedge clk);
    check("gnt_dropped", 64'(gnt0 | gnt1), 64'd0);
    check("gnt_cycles", 64'(hc), 64'(ncyc));
  endtask

  task automatic drain(input logic ch, input bit gap, input bit regrant);
    res_t r;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      fft_finish_i = 1'b1;
      fft_Xr_i = 19'(i * 5 - 60);
      fft_Xi_i = 19'(1000 - 7 * i);
      r.ch = ch; r.idx = 5'(i); r.last = (i == 31);
      r.xr = fft_Xr_i; r.xi = fft_Xi_i;
      exp_res.push_back(r);
      if (gap) begin
        @(posedge clk); #1;
        fft_finish_i = 1'b0;
      end
    end
    @(posedge clk); #1;
    fft_finish_i = 1'b0;
    @(posedge clk); #1;
    if (regrant) check("regrant_after_last", 64'(gnt0 | gnt1), 64'd1);
    check("drain_empty", 64'(exp_res.size()), 64'd0);
    check("err_clean", 64'(err_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int k;
    @(posedge clk); #1;
    reset_dut();

    // busy holds off grant, then single req0 frame of samples 0..31
    fft_busy_i = 1'b1;
    req0 = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("busy_blocks", 64'(gnt0 | gnt1), 64'd0);
    fft_busy_i = 1'b0;
    wait_gnt(1'b0);
    req0 = 1'b0;
    feed(1'b0, 1'b0, 14'd0, 32);
    drain(1'b0, 1'b0, 1'b0);

    // both requesting from reset: ch0 then ch1
    reset_dut();
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(1'b0);
    feed(1'b0, 1'b0, 14'd50, 32);
    drain(1'b0, 1'b0, 1'b1);
    wait_gnt(1'b1);
    req0 = 1'b0; req1 = 1'b0;
    feed(1'b1, 1'b0, 14'd300, 32);
    drain(1'b1, 1'b0, 1'b0);

    // valid gaps every other cycle; finish strobes also gapped
    req1 = 1'b1;
    wait_gnt(1'b1);
    req1 = 1'b0;
    feed(1'b1, 1'b1, 14'h3F00, 64);
    drain(1'b1, 1'b1, 1'b0);

    // watchdog: no finish after feed
    req0 = 1'b1;
    wait_gnt(1'b0);
    req0 = 1'b0;
    feed(1'b0, 1'b0, 14'd100, 32);
    k = 0;
    while (!err_o && k < 2 * TO) begin
      @(posedge clk); #1;
      k++;
    end
    check("timeout_cycles", 64'(k), 64'(TO));
    check("timeout_err", 64'(err_o), 64'd1);
    req1 = 1'b1;
    wait_gnt(1'b1);
    req1 = 1'b0;

    // reset mid-feed after 10 samples
    reset_dut();
    req0 = 1'b1;
    wait_gnt(1'b0);
    req0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drv(1'b0, 1'b1, 14'(200 + i));
      exp_x.push_back(14'(200 + i));
      @(posedge clk); #1;
    end
    drv(1'b0, 1'b0, '0);
    reset_dut();
    repeat (20) begin @(posedge clk); #1; end
    check("abort_x_empty", 64'(exp_x.size()), 64'd0);

    // finish strobe while idle
    check("idle_err_before", 64'(err_o), 64'd0);
    fft_finish_i = 1'b1;
    fft_Xr_i = 19'd5;
    @(posedge clk); #1;
    fft_finish_i = 1'b0;
    check("idle_finish_err", 64'(err_o), 64'd1);
    @(negedge clk);
    check("idle_no_out", 64'(out_valid), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("final_res_empty", 64'(exp_res.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
